// File: rtl/mac_rx_bank_scheduler.sv
// MAC receive sequencer for a two-bank (ping-pong) packet buffer.
// Owns request handshake, bank allocation, write addressing, truncation and packet counting.
module mac_rx_bank_scheduler #(
    parameter int _ben_w_mac  = 2,
    parameter int _addr_w_mem = 9
) (
    input  logic                   mac_clk_i,
    input  logic                   mac_rst_i,
    input  logic                   mac_rxda_i,
    input  logic                   mac_rxsop_i,
    input  logic                   mac_rxeop_i,
    input  logic                   mac_rxdv_i,
    input  logic [_ben_w_mac-1:0]  mac_ben_i,
    output logic                   mac_rxrqrd_o,
    output logic                   mem_we_o,
    output logic                   mem_bank_o,
    output logic [_addr_w_mem-1:0] mem_addr_o,
    output logic [_ben_w_mac-1:0]  mem_ben_o,
    output logic [1:0]             bank_full_o,
    output logic [1:0]             bank_trunc_o,
    output logic [_addr_w_mem:0]   bank0_len_o,
    output logic [_addr_w_mem:0]   bank1_len_o,
    input  logic [1:0]             bank_release_i,
    output logic [31:0]            pkt_count_o
);

    localparam logic [_addr_w_mem:0] DEPTH = {1'b1, {_addr_w_mem{1'b0}}};
    localparam logic [_addr_w_mem:0] ONE   = {{_addr_w_mem{1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WR   = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic                   last_bank_r;
    logic                   active_bank_r;
    logic                   wait_sop_r;
    logic                   trunc_cur_r;
    logic [_addr_w_mem:0]   cnt_r;
    logic                   rqrd_r;
    logic                   mem_we_r;
    logic                   mem_bank_r;
    logic [_addr_w_mem-1:0] mem_addr_r;
    logic [_ben_w_mac-1:0]  mem_ben_r;
    logic [1:0]             bank_full_r;
    logic [1:0]             bank_trunc_r;
    logic [_addr_w_mem:0]   bank0_len_r;
    logic [_addr_w_mem:0]   bank1_len_r;
    logic [31:0]            pkt_count_r;

    logic                   sel_bank_s;
    logic                   start_s;
    logic                   accept_s;
    logic                   sop_s;
    logic                   at_cap_s;
    logic                   wr_s;
    logic                   trunc_set_s;
    logic                   close_s;
    logic                   trunc_s;
    logic [_addr_w_mem:0]   len_s;
    logic [_addr_w_mem-1:0] addr_s;

    // State register.
    always_ff @(posedge mac_clk_i) begin
        if (mac_rst_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:  state_s = start_s ? S_WR : S_IDLE;
            S_WR:    state_s = close_s ? S_IDLE : S_WR;
            default: state_s = S_IDLE;
        endcase
    end

    // Decode of the current cycle: bank choice, word acceptance, write and close.
    always_comb begin
        sel_bank_s  = bank_full_r[~last_bank_r] ? last_bank_r : ~last_bank_r;
        start_s     = (state_r == S_IDLE) && mac_rxda_i && !(&bank_full_r);
        accept_s    = (state_r == S_WR) && mac_rxdv_i;
        sop_s       = accept_s && mac_rxsop_i;
        at_cap_s    = (cnt_r == DEPTH);
        // Words seen while hunting for sop are dropped, eop included.
        wr_s        = sop_s || (accept_s && !wait_sop_r && !at_cap_s);
        trunc_set_s = accept_s && !mac_rxsop_i && !wait_sop_r && at_cap_s;
        close_s     = accept_s && mac_rxeop_i && (mac_rxsop_i || !wait_sop_r);
        if (sop_s) begin
            trunc_s = 1'b0;
            len_s   = ONE;
            addr_s  = {_addr_w_mem{1'b0}};
        end else begin
            trunc_s = trunc_cur_r | trunc_set_s;
            len_s   = at_cap_s ? DEPTH : (cnt_r + ONE);
            addr_s  = cnt_r[_addr_w_mem-1:0];
        end
    end

    // Request handshake, write port and per-packet bookkeeping.
    always_ff @(posedge mac_clk_i) begin
        if (mac_rst_i) begin
            rqrd_r        <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_bank_r    <= 1'b0;
            mem_addr_r    <= {_addr_w_mem{1'b0}};
            mem_ben_r     <= {_ben_w_mac{1'b0}};
            active_bank_r <= 1'b0;
            wait_sop_r    <= 1'b1;
            trunc_cur_r   <= 1'b0;
            cnt_r         <= {(_addr_w_mem+1){1'b0}};
        end else begin
            if (state_r == S_IDLE) begin
                rqrd_r <= start_s;
            end else begin
                rqrd_r <= close_s ? 1'b0 : mac_rxda_i;
            end
            mem_we_r  <= wr_s;
            mem_ben_r <= mac_ben_i;
            if (wr_s) begin
                mem_addr_r <= addr_s;
                mem_bank_r <= active_bank_r;
                cnt_r      <= sop_s ? ONE : (cnt_r + ONE);
            end else if (start_s) begin
                cnt_r <= {(_addr_w_mem+1){1'b0}};
            end
            if (start_s) begin
                active_bank_r <= sel_bank_s;
                wait_sop_r    <= 1'b1;
                trunc_cur_r   <= 1'b0;
            end else if (sop_s) begin
                wait_sop_r    <= 1'b0;
                trunc_cur_r   <= 1'b0;
            end else if (trunc_set_s) begin
                trunc_cur_r   <= 1'b1;
            end
        end
    end

    // Bank status: release clears, close sets; both may land on different banks together.
    always_ff @(posedge mac_clk_i) begin
        if (mac_rst_i) begin
            bank_full_r  <= 2'b00;
            bank_trunc_r <= 2'b00;
            bank0_len_r  <= {(_addr_w_mem+1){1'b0}};
            bank1_len_r  <= {(_addr_w_mem+1){1'b0}};
            pkt_count_r  <= 32'd0;
            last_bank_r  <= 1'b1;
        end else begin
            if (bank_release_i[0] && bank_full_r[0]) begin
                bank_full_r[0]  <= 1'b0;
                bank_trunc_r[0] <= 1'b0;
                bank0_len_r     <= {(_addr_w_mem+1){1'b0}};
            end
            if (bank_release_i[1] && bank_full_r[1]) begin
                bank_full_r[1]  <= 1'b0;
                bank_trunc_r[1] <= 1'b0;
                bank1_len_r     <= {(_addr_w_mem+1){1'b0}};
            end
            if (close_s) begin
                pkt_count_r <= pkt_count_r + 32'd1;
                last_bank_r <= active_bank_r;
                if (active_bank_r == 1'b0) begin
                    bank_full_r[0]  <= 1'b1;
                    bank_trunc_r[0] <= trunc_s;
                    bank0_len_r     <= len_s;
                end else begin
                    bank_full_r[1]  <= 1'b1;
                    bank_trunc_r[1] <= trunc_s;
                    bank1_len_r     <= len_s;
                end
            end
        end
    end

    assign mac_rxrqrd_o = rqrd_r;
    assign mem_we_o     = mem_we_r;
    assign mem_bank_o   = mem_bank_r;
    assign mem_addr_o   = mem_addr_r;
    assign mem_ben_o    = mem_ben_r;
    assign bank_full_o  = bank_full_r;
    assign bank_trunc_o = bank_trunc_r;
    assign bank0_len_o  = bank0_len_r;
    assign bank1_len_o  = bank1_len_r;
    assign pkt_count_o  = pkt_count_r;

endmodule

// File: tb/tb_mac_rx_bank_scheduler.sv
// Directed self-checking bench for mac_rx_bank_scheduler with a write-port monitor.
module tb_mac_rx_bank_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxda = 1'b0;
    logic       rxsop = 1'b0;
    logic       rxeop = 1'b0;
    logic       rxdv = 1'b0;
    logic [1:0] ben = 2'b00;
    logic [1:0] rel = 2'b00;
    logic       rqrd;
    logic       we;
    logic       bank;
    logic [8:0] addr;
    logic [1:0] mben;
    logic [1:0] full;
    logic [1:0] trunc;
    logic [9:0] len0;
    logic [9:0] len1;
    logic [31:0] pkt_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic       clr_req = 1'b0;
    int         wr_cnt = 0;
    int         seq_err = 0;
    logic [8:0] wr_first = 9'd0;
    logic [8:0] wr_last = 9'd0;
    logic       wr_bank = 1'b0;
    logic [1:0] wr_ben = 2'b00;

    mac_rx_bank_scheduler #(._ben_w_mac(2), ._addr_w_mem(9)) dut (
        .mac_clk_i      (clk),
        .mac_rst_i      (rst),
        .mac_rxda_i     (rxda),
        .mac_rxsop_i    (rxsop),
        .mac_rxeop_i    (rxeop),
        .mac_rxdv_i     (rxdv),
        .mac_ben_i      (ben),
        .mac_rxrqrd_o   (rqrd),
        .mem_we_o       (we),
        .mem_bank_o     (bank),
        .mem_addr_o     (addr),
        .mem_ben_o      (mben),
        .bank_full_o    (full),
        .bank_trunc_o   (trunc),
        .bank0_len_o    (len0),
        .bank1_len_o    (len1),
        .bank_release_i (rel),
        .pkt_count_o    (pkt_cnt)
    );

    always #5 clk = ~clk;

    // Write-port monitor: counts writes and flags any address out of sequence.
    always @(negedge clk) begin
        if (clr_req) begin
            wr_cnt  <= 0;
            seq_err <= 0;
        end else if (we) begin
            if (int'(addr) != wr_cnt) seq_err <= seq_err + 1;
            if (wr_cnt == 0) wr_first <= addr;
            wr_last <= addr;
            wr_bank <= bank;
            wr_ben  <= mben;
            wr_cnt  <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_log();
        #1 clr_req = 1'b1;
        @(negedge clk);
        #1 clr_req = 1'b0;
    endtask

    task automatic rel_pulse(input logic [1:0] v);
        rel = v;
        @(negedge clk);
        rel = 2'b00;
    endtask

    // Raise rxda, wait for the read request, then stream n words.
    task automatic send_words(input int n, input logic [1:0] b, input bit with_sop,
                              input bit with_eop, input logic [1:0] rel_last);
        bit got = 0;
        rxda = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rqrd) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("rq_wait", 32'd0, 32'd1);
        for (int k = 0; k < n; k++) begin
            rxdv  = 1'b1;
            rxsop = with_sop && (k == 0);
            rxeop = with_eop && (k == n - 1);
            rel   = (k == n - 1) ? rel_last : 2'b00;
            ben   = b;
            @(negedge clk);
        end
        rxdv  = 1'b0;
        rxsop = 1'b0;
        rxeop = 1'b0;
        rel   = 2'b00;
        rxda  = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_writes(input string tag, input int n, input logic b,
                              input logic [8:0] last);
        chk({tag, "_wr_cnt"}, wr_cnt, n);
        chk({tag, "_wr_bank"}, {31'd0, wr_bank}, {31'd0, b});
        chk({tag, "_wr_first"}, {23'd0, wr_first}, 32'd0);
        chk({tag, "_wr_last"}, {23'd0, wr_last}, {23'd0, last});
        chk({tag, "_wr_seq"}, seq_err, 32'd0);
    endtask

    initial begin
        int hi;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_rqrd", {31'd0, rqrd}, 32'd0);
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_full", {30'd0, full}, 32'd0);
        chk("rst_trunc", {30'd0, trunc}, 32'd0);
        chk("rst_len0", {22'd0, len0}, 32'd0);
        chk("rst_len1", {22'd0, len1}, 32'd0);
        chk("rst_count", pkt_cnt, 32'd0);
        chk("rst_addr", {23'd0, addr}, 32'd0);
        chk("rst_ben", {30'd0, mben}, 32'd0);

        // Single 4-word packet into bank 0
        clr_log();
        send_words(4, 2'b11, 1, 1, 2'b00);
        chk_writes("p4", 4, 1'b0, 9'd3);
        chk("p4_ben", {30'd0, wr_ben}, 32'd3);
        chk("p4_full", {30'd0, full}, 32'd1);
        chk("p4_len0", {22'd0, len0}, 32'd4);
        chk("p4_trunc", {30'd0, trunc}, 32'd0);
        chk("p4_count", pkt_cnt, 32'd1);
        rel_pulse(2'b01);
        chk("rel0_full", {30'd0, full}, 32'd0);
        chk("rel0_len0", {22'd0, len0}, 32'd0);

        // Back-to-back 3 and 5 words: last bank was 0, so bank 1 first, then bank 0
        clr_log();
        send_words(3, 2'b10, 1, 1, 2'b00);
        chk_writes("p3", 3, 1'b1, 9'd2);
        chk("p3_len1", {22'd0, len1}, 32'd3);
        clr_log();
        send_words(5, 2'b11, 1, 1, 2'b00);
        chk_writes("p5", 5, 1'b0, 9'd4);
        chk("p5_len0", {22'd0, len0}, 32'd5);
        chk("p5_full", {30'd0, full}, 32'd3);
        chk("p5_count", pkt_cnt, 32'd3);

        // Both banks full: request must stay low
        rxda = 1'b1;
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rqrd) hi++;
        end
        chk("blk_rqrd_hi", hi, 32'd0);
        rel_pulse(2'b01);
        chk("blk_rel_full", {30'd0, full}, 32'd2);
        chk("blk_rel_len1", {22'd0, len1}, 32'd3);

        // 520-word packet truncates at 512 words
        clr_log();
        send_words(520, 2'b11, 1, 1, 2'b00);
        chk_writes("p520", 512, 1'b0, 9'd511);
        chk("p520_len0", {22'd0, len0}, 32'd512);
        chk("p520_trunc", {30'd0, trunc}, 32'd1);
        chk("p520_full", {30'd0, full}, 32'd3);
        chk("p520_count", pkt_cnt, 32'd4);
        rel_pulse(2'b01);
        chk("p520_rel_trunc", {30'd0, trunc}, 32'd0);
        clr_log();
        send_words(2, 2'b01, 1, 1, 2'b00);
        chk_writes("p2", 2, 1'b0, 9'd1);
        chk("p2_len0", {22'd0, len0}, 32'd2);
        chk("p2_trunc", {30'd0, trunc}, 32'd0);
        chk("p2_count", pkt_cnt, 32'd5);

        // Close bank 0 while releasing bank 1, plus an ignored release of bank 0
        rel_pulse(2'b01);
        chk("cr_pre_full", {30'd0, full}, 32'd2);
        clr_log();
        send_words(3, 2'b01, 1, 1, 2'b11);
        chk_writes("cr", 3, 1'b0, 9'd2);
        chk("cr_full", {30'd0, full}, 32'd1);
        chk("cr_len0", {22'd0, len0}, 32'd3);
        chk("cr_len1", {22'd0, len1}, 32'd0);
        chk("cr_trunc", {30'd0, trunc}, 32'd0);
        chk("cr_count", pkt_cnt, 32'd6);

        // One-word packet with ben 00 lands in bank 1
        clr_log();
        send_words(1, 2'b00, 1, 1, 2'b00);
        chk_writes("p1", 1, 1'b1, 9'd0);
        chk("p1_ben", {30'd0, wr_ben}, 32'd0);
        chk("p1_len1", {22'd0, len1}, 32'd1);
        chk("p1_full", {30'd0, full}, 32'd3);
        chk("p1_count", pkt_cnt, 32'd7);

        // Reset mid-packet; the tail without sop is dropped
        rel_pulse(2'b11);
        chk("mr_rel_full", {30'd0, full}, 32'd0);
        send_words(3, 2'b11, 1, 0, 2'b00);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_full", {30'd0, full}, 32'd0);
        chk("mr_count", pkt_cnt, 32'd0);
        chk("mr_rqrd", {31'd0, rqrd}, 32'd0);
        clr_log();
        send_words(3, 2'b11, 0, 1, 2'b00);
        chk("mr_tail_wr", wr_cnt, 32'd0);
        chk("mr_tail_full", {30'd0, full}, 32'd0);
        chk("mr_tail_count", pkt_cnt, 32'd0);
        clr_log();
        send_words(4, 2'b11, 1, 1, 2'b00);
        chk_writes("mr_pkt", 4, 1'b0, 9'd3);
        chk("mr_pkt_full", {30'd0, full}, 32'd1);
        chk("mr_pkt_len0", {22'd0, len0}, 32'd4);
        chk("mr_pkt_count", pkt_cnt, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
